seq_stream_gen: RTL and testbench
=================================

# seq_stream_gen

Serial bit-stream generator that drives the `x` input of the overlapping Mealy sequence detector. It shifts a loaded word out MSB-first, one bit per clock. A built-in golden model flags every overlapping occurrence of the target pattern in the emitted stream, so a bench can compare `detect` against `exp_detect` cycle by cycle. It sits on the stimulus side of the detector as the transmitter end of the `x`/`detect` interface.

## Interface
- `DATA_W`, 16: width of the loaded word; bits emitted per burst.
- `PAT_W`, 4: target pattern length.
- `PAT`, 4'b1011: target pattern, MSB = first bit on the wire.
- `CNT_W`, 5: width of `exp_count`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `data`  in  DATA_W  word to emit; captured with `start`.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a stream bit this cycle.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse after the last bit.
- `exp_detect`  out  1  combinational; the current `x` completes `PAT` (Mealy timing).
- `exp_count`  out  CNT_W  registered count of detections since the last `start`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE → SHIFT:** on `start`=1. Captures `data` into the shift register, sets the bit counter to DATA_W-1, and clears the history, fill counter and `exp_count`.
- **SHIFT:** `x` = shift-register MSB and `x_valid`=1. Each edge shifts left and decrements the counter.
  - When the counter reaches 0 and `loop`=0, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **History:** the last PAT_W-1 emitted bits, plus a fill counter that saturates at PAT_W-1.
- **Match rule:** `exp_detect` = `x_valid` & (fill == PAT_W-1) & ({hist, x} == PAT). Overlap is allowed: history is never cleared on a match.
- **Count:** `exp_count` increments on each edge where `exp_detect`=1. It saturates at 2^CNT_W-1 and never wraps.
- **Ignored `start`:** `start` in SHIFT or DONE is ignored; `data` is not re-captured.
- **Reset values:** state IDLE, `x`=0, `x_valid`=0, `busy`=0, `done`=0, `exp_count`=0, history and fill cleared.
- **Reset mid-burst:** aborts the burst on the next edge. Outputs return to their reset values and no `done` is pulsed.

## Timing
- `start` sampled at edge N: first bit (`data[DATA_W-1]`) is valid in cycle N+1, last bit in cycle N+DATA_W.
- `done` is high in cycle N+DATA_W+1.
- `busy` equals `x_valid`: high from cycle N+1 through N+DATA_W.
- `exp_detect` is asserted in the same cycle as the completing bit, matching the detector's Mealy `detect`.
- `exp_count` reflects that detection one cycle later.
- Earliest back-to-back burst: `start` accepted in IDLE at the edge ending the DONE cycle's successor, giving a minimum gap of 2 idle bit slots.

## Configuration
- **`SEQ_GEN_LOOP_EN` defined:** adds input port `loop` (1 bit).
  - `loop` is sampled on the edge ending the last bit of a word.
  - If `loop`=1: reload the same captured word, stay in SHIFT with no gap and no `done`, and keep history, fill and `exp_count`, so matches spanning the word boundary are detected.
- **Not defined:** no `loop` port exists; behaviour is identical to `loop`=0.

## Test plan
- **Reset:** hold `reset` for 2 cycles → `x`=0, `x_valid`=0, `busy`=0, `done`=0, `exp_count`=0.
- **Overlapping matches:** `start` with `data`=16'hB6DB → `x` = 1011011011011011. `exp_detect` is high on bit indices 3, 6, 9, 12 and 15. `done` pulses once in cycle N+17 and `exp_count`=5.
- **No matches:** `data`=16'hFFFF, then separately 16'h0000 → `exp_detect` never asserted and `exp_count`=0. Also assert `start` mid-burst and confirm it is ignored (the stream is unchanged).
- **Reset mid-burst:** `data`=16'hB6DB with `reset` asserted after bit 5 → next cycle `x_valid`=0, `busy`=0, `exp_count`=0, and no `done` pulse.
- **Loop mode (`SEQ_GEN_LOOP_EN`):** `data`=16'hC002 with `loop`=1 for the first word and 0 for the second → 32 contiguous valid bits. `exp_detect` appears only at global bit 17 (the boundary match 1011). Final `exp_count`=1 and a single `done` pulse.
- **Saturation:** with CNT_W=2 and `data`=16'hB6DB → `exp_count` stops at 3.

Source files
------------

// File: rtl/seq_stream_gen_if.sv
// seq_stream_gen_if
//   Bundles the load request and the serial stream / golden-model outputs of
//   seq_stream_gen. Clock and reset are not part of the bundle.
//   Signals:
//     start      load request (consumer -> generator)
//     data       word to emit, captured with start
//     x          serial stream bit
//     x_valid    x carries a stream bit this cycle
//     busy       burst in progress
//     done       one-cycle pulse after the last bit
//     exp_detect golden-model match on the current bit (combinational)
//     exp_count  registered number of matches since the last start
//   Modports: master = side that requests bursts, slave = the generator.
interface seq_stream_gen_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
);
   logic              start;
   logic [DATA_W-1:0] data;
   logic              x;
   logic              x_valid;
   logic              busy;
   logic              done;
   logic              exp_detect;
   logic [CNT_W-1:0]  exp_count;

   modport master (
      output start, data,
      input  x, x_valid, busy, done, exp_detect, exp_count
   );

   modport slave (
      input  start, data,
      output x, x_valid, busy, done, exp_detect, exp_count
   );
endinterface

// File: rtl/seq_stream_gen.sv
// seq_stream_gen
//   Serial bit-stream generator feeding a Mealy sequence detector. A loaded
//   word is shifted out MSB-first, one bit per clock, while a built-in golden
//   model flags every overlapping occurrence of PAT in the emitted stream.
//   Optional feature macro: SEQ_GEN_LOOP_EN (adds the loop input, which
//   re-emits the captured word back-to-back while keeping match history).
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     loop   (SEQ_GEN_LOOP_EN only) repeat word, sampled at the last bit
//     bus    seq_stream_gen_if.slave: start/data in, stream + model out
module seq_stream_gen #(
   parameter int               DATA_W = 16,
   parameter int               PAT_W  = 4,
   parameter logic [PAT_W-1:0] PAT    = 4'b1011,
   parameter int               CNT_W  = 5
) (
   input logic             clk,
   input logic             reset,
`ifdef SEQ_GEN_LOOP_EN
   input logic             loop,
`endif
   seq_stream_gen_if.slave bus
);
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q;
   logic [DATA_W-1:0]  sreg_q;
   logic [BIT_W-1:0]   bit_cnt_q;
   logic [PAT_W-2:0]   hist_q;
   logic [FILL_W-1:0]  fill_q;
   logic [CNT_W-1:0]   count_q;
   logic               x_valid_q;
   logic               busy_q;
   logic               done_q;
`ifdef SEQ_GEN_LOOP_EN
   logic [DATA_W-1:0]  word_q;    // captured word, reloaded on loop
`endif

   logic               x_d;
   logic [PAT_W-1:0]   window_d;  // previous PAT_W-1 bits followed by current bit
   logic               detect_d;

   always_comb begin
      x_d      = x_valid_q & sreg_q[DATA_W-1];
      window_d = {hist_q, x_d};
      detect_d = x_valid_q && (fill_q == FILL_MAX) && (window_d == PAT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         hist_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQ_GEN_LOOP_EN
         word_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sreg_q    <= bus.data;
`ifdef SEQ_GEN_LOOP_EN
                  word_q    <= bus.data;
`endif
                  bit_cnt_q <= BIT_W'(DATA_W - 1);
                  hist_q    <= '0;
                  fill_q    <= '0;
                  count_q   <= '0;
                  x_valid_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               // History is never cleared on a match, so overlaps are found.
               hist_q <= window_d[PAT_W-2:0];
               if (fill_q != FILL_MAX)
                  fill_q <= fill_q + 1'b1;
               if (detect_d && (count_q != {CNT_W{1'b1}}))
                  count_q <= count_q + 1'b1;
               if (bit_cnt_q == '0) begin
`ifdef SEQ_GEN_LOOP_EN
                  if (loop) begin
                     // Seamless repeat: history, fill and count carry over.
                     sreg_q    <= word_q;
                     bit_cnt_q <= BIT_W'(DATA_W - 1);
                  end else
`endif
                  begin
                     x_valid_q <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= DONE;
                  end
               end else begin
                  sreg_q    <= {sreg_q[DATA_W-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q - 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.x          = x_d;
   assign bus.x_valid    = x_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.exp_detect = detect_d;
   assign bus.exp_count  = count_q;
endmodule

// File: tb/tb_seq_stream_gen.sv
module tb_seq_stream_gen;
   logic        clk = 1'b0;
   logic        reset_s = 1'b1;
   logic        start_s = 1'b0;
   logic [15:0] data_s = '0;
   logic        loop_s = 1'b0;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   seq_stream_gen_if #(.DATA_W(16), .CNT_W(5)) bus ();
   seq_stream_gen_if #(.DATA_W(16), .CNT_W(2)) bus2 ();

   assign bus.start  = start_s;
   assign bus.data   = data_s;
   assign bus2.start = start_s;
   assign bus2.data  = data_s;

   seq_stream_gen #(.DATA_W(16), .PAT_W(4), .PAT(4'b1011), .CNT_W(5)) dut (
      .clk   (clk),
      .reset (reset_s),
`ifdef SEQ_GEN_LOOP_EN
      .loop  (loop_s),
`endif
      .bus   (bus)
   );

   seq_stream_gen #(.DATA_W(16), .PAT_W(4), .PAT(4'b1011), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .reset (reset_s),
`ifdef SEQ_GEN_LOOP_EN
      .loop  (loop_s),
`endif
      .bus   (bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] data;
      int          words;
      bit          inject;
      int          exp_count;
   } vec_t;

   // Emit one burst and compare every bit slot against a reference built
   // from the emitted bit sequence with a sliding 4-bit window.
   task automatic burst(input logic [15:0] d, input int words, input bit inject,
                        input string tag, output int final_count);
      logic bits[$];
      logic exp_det;
      int   cnt, cnt2, len;
      bits = {};
      for (int w = 0; w < words; w++)
         for (int b = 15; b >= 0; b--)
            bits.push_back(d[b]);
      len  = bits.size();
      cnt  = 0;
      cnt2 = 0;
      start_s = 1'b1;
      data_s  = d;
      loop_s  = (words > 1);
      step();
      start_s = 1'b0;
      for (int i = 0; i < len; i++) begin
         loop_s = ((i / 16) < (words - 1));
         if (inject && i == 5) begin
            start_s = 1'b1;
            data_s  = ~d;
         end else begin
            start_s = 1'b0;
         end
         exp_det = (i >= 3) && ({bits[i-3], bits[i-2], bits[i-1], bits[i]} == 4'b1011);
         chk($sformatf("%s x_valid[%0d]", tag, i), {31'd0, bus.x_valid}, 32'd1);
         chk($sformatf("%s busy[%0d]", tag, i), {31'd0, bus.busy}, 32'd1);
         chk($sformatf("%s x[%0d]", tag, i), {31'd0, bus.x}, {31'd0, bits[i]});
         chk($sformatf("%s detect[%0d]", tag, i), {31'd0, bus.exp_detect}, {31'd0, exp_det});
         chk($sformatf("%s count[%0d]", tag, i), {27'd0, bus.exp_count}, cnt);
         chk($sformatf("%s done_low[%0d]", tag, i), {31'd0, bus.done}, 32'd0);
         if (exp_det) begin
            if (cnt < 31) cnt++;
            if (cnt2 < 3) cnt2++;
         end
         step();
      end
      start_s = 1'b0;
      loop_s  = 1'b0;
      chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, " idle x_valid"}, {31'd0, bus.x_valid}, 32'd0);
      chk({tag, " final count"}, {27'd0, bus.exp_count}, cnt);
      chk({tag, " sat count"}, {30'd0, bus2.exp_count}, cnt2);
      step();
      chk({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
      $display("[TB] burst %s data=%04h words=%0d matches=%0d", tag, d, words, cnt);
      final_count = cnt;
   endtask

   initial begin
      vec_t vecs[$];
      int   fc;
      bit   seen_done;
      int   nwords;

      vecs.push_back('{16'hB6DB, 1, 1'b0, 5});
      vecs.push_back('{16'hFFFF, 1, 1'b1, 0});
      vecs.push_back('{16'h0000, 1, 1'b1, 0});
      vecs.push_back('{16'hB6DB, 1, 1'b1, 5});
`ifdef SEQ_GEN_LOOP_EN
      vecs.push_back('{16'hC002, 2, 1'b0, 1});
`endif

      // Reset held for two cycles.
      reset_s = 1'b1;
      step();
      step();
      chk("reset x", {31'd0, bus.x}, 32'd0);
      chk("reset x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("reset busy", {31'd0, bus.busy}, 32'd0);
      chk("reset done", {31'd0, bus.done}, 32'd0);
      chk("reset count", {27'd0, bus.exp_count}, 32'd0);
      $display("[TB] reset checked");
      reset_s = 1'b0;
      step();

      for (int v = 0; v < vecs.size(); v++) begin
         burst(vecs[v].data, vecs[v].words, vecs[v].inject, $sformatf("vec%0d", v), fc);
         chk($sformatf("vec%0d table count", v), fc, vecs[v].exp_count);
      end

      // Reset in the middle of a burst: abort, no done pulse.
      start_s = 1'b1;
      data_s  = 16'hB6DB;
      step();
      start_s = 1'b0;
      for (int i = 0; i < 6; i++) step();
      reset_s = 1'b1;
      step();
      reset_s = 1'b0;
      chk("midrst x_valid", {31'd0, bus.x_valid}, 32'd0);
      chk("midrst busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst count", {27'd0, bus.exp_count}, 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done || bus.x_valid) seen_done = 1'b1;
         step();
      end
      chk("midrst no done", {31'd0, seen_done}, 32'd0);
      $display("[TB] reset mid-burst checked");

      // Randomized bursts against the reference.
      for (int r = 0; r < 20; r++) begin
`ifdef SEQ_GEN_LOOP_EN
         nwords = int'($urandom_range(1, 2));
`else
         nwords = 1;
`endif
         burst(16'($urandom), nwords, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", r), fc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
